// File: rtl/gf180mcu_osu_sc_9t_clkdiv_pkg.sv
// gf180mcu_osu_sc_9t_clkdiv_pkg: shared types, defaults and helpers for the clock divider bank
package gf180mcu_osu_sc_9t_clkdiv_pkg;
  typedef enum logic {STOP = 1'b0, RUNNING = 1'b1} state_t;
  localparam int DEF_NCH = 4;
  localparam int DEF_WIDTH = 8;
  function automatic int unsigned half_period(input int unsigned d);
    return d + 1;
  endfunction
endpackage

// File: rtl/gf180mcu_osu_sc_9t_clkdiv_chan.sv
// gf180mcu_osu_sc_9t_clkdiv_chan: one divider channel (counter, phase, ratio/polarity shadows, run FSM)
module gf180mcu_osu_sc_9t_clkdiv_chan
  import gf180mcu_osu_sc_9t_clkdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  input  logic             inv,
  input  logic             sync,
  output logic             y,
  output logic             run
);
  state_t st;
  logic [WIDTH-1:0] cnt, div_act;
  logic phase, inv_act;
  always_ff @(posedge clk) begin
    if (!rn) begin
      st <= STOP;
      cnt <= '0;
      phase <= 1'b0;
      div_act <= '0;
      inv_act <= 1'b0;
      y <= 1'b0;
    end else if (sync && st == RUNNING) begin
      cnt <= '0;
      phase <= 1'b1;
      div_act <= div;
      y <= ~inv_act;
    end else if (st == STOP) begin
      st <= en ? RUNNING : STOP;
      cnt <= '0;
      phase <= en;
      div_act <= div;
      inv_act <= inv;
      y <= en ^ inv;
    end else if (cnt != div_act) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
      // rising toggle is the period boundary: stop or reload the ratio here only
      if (phase) begin
        phase <= 1'b0;
        y <= inv_act;
      end else if (!en) begin
        st <= STOP;
        y <= inv_act;
      end else begin
        phase <= 1'b1;
        div_act <= div;
        y <= ~inv_act;
      end
    end
  end
  assign run = (st == RUNNING);
endmodule

// File: rtl/gf180mcu_osu_sc_9t_clkdiv_bank.sv
// gf180mcu_osu_sc_9t_clkdiv_bank: NCH-channel 50%-duty clock divider/inverter bank
// Define CLKDIV_SYNC_ALIGN_EN to add the SYNC phase-align strobe port.
module gf180mcu_osu_sc_9t_clkdiv_bank
  import gf180mcu_osu_sc_9t_clkdiv_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic [NCH-1:0]       EN,
  input  logic [NCH*WIDTH-1:0] DIV,
  input  logic [NCH-1:0]       INV,
  output logic [NCH-1:0]       Y,
  output logic [NCH-1:0]       RUN
`ifdef CLKDIV_SYNC_ALIGN_EN
  ,
  input  logic                 SYNC
`endif
);
  logic sync_all;
`ifdef CLKDIV_SYNC_ALIGN_EN
  assign sync_all = SYNC;
`else
  assign sync_all = 1'b0;
`endif
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    gf180mcu_osu_sc_9t_clkdiv_chan #(.WIDTH(WIDTH)) u_ch (
      .clk(CLK),
      .rn(RN),
      .en(EN[i]),
      .div(DIV[i*WIDTH +: WIDTH]),
      .inv(INV[i]),
      .sync(sync_all),
      .y(Y[i]),
      .run(RUN[i])
    );
  end
endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_clkdiv_bank.sv
// tb_gf180mcu_osu_sc_9t_clkdiv_bank: vector table plus scoreboarded waveform sequences
module tb_gf180mcu_osu_sc_9t_clkdiv_bank;
  import gf180mcu_osu_sc_9t_clkdiv_pkg::*;
  logic clk = 1'b0;
  logic rn;
  logic [3:0] en, inv, y, run;
  logic [31:0] div;
`ifdef CLKDIV_SYNC_ALIGN_EN
  logic sync = 1'b0;
`endif
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [3:0] y;
    logic [3:0] run;
    string name;
  } exp_t;
  exp_t q[$];
  typedef struct {
    logic rn;
    logic [3:0] en;
    logic [3:0] inv;
    logic [3:0] y;
    logic [3:0] run;
  } vec_t;
  vec_t tv[9];

  gf180mcu_osu_sc_9t_clkdiv_bank dut (
    .CLK(clk),
    .RN(rn),
    .EN(en),
    .DIV(div),
    .INV(inv),
    .Y(y),
    .RUN(run)
`ifdef CLKDIV_SYNC_ALIGN_EN
    ,
    .SYNC(sync)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string name, input logic [3:0] ey, input logic [3:0] er);
    exp_t e;
    q.push_back('{y: ey, run: er, name: name});
    tick();
    e = q.pop_front();
    total++;
    if (y !== e.y || run !== e.run) begin
      bad++;
      $display("FAIL %s: Y=%b RUN=%b expected Y=%b RUN=%b", e.name, y, run, e.y, e.run);
    end
  endtask

  task automatic do_reset();
    rn = 1'b0;
    en = '0;
    inv = '0;
    div = '0;
    cyc("reset", 4'b0000, 4'b0000);
    rn = 1'b1;
  endtask

  initial begin
    int unsigned h;
    rn = 1'b0;
    en = '0;
    inv = '0;
    div = '0;
    tv = '{
      '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
      '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
      '{1'b0, 4'b0000, 4'b0010, 4'b0000, 4'b0000},
      '{1'b1, 4'b0000, 4'b0010, 4'b0010, 4'b0000},
      '{1'b1, 4'b0000, 4'b0101, 4'b0101, 4'b0000},
      '{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0001},
      '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001},
      '{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0001},
      '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000}
    };
    for (int i = 0; i < 9; i++) begin
      rn = tv[i].rn;
      en = tv[i].en;
      inv = tv[i].inv;
      cyc($sformatf("vec%0d", i), tv[i].y, tv[i].run);
    end

    // DIV=2: 3 high / 3 low, 10 periods
    do_reset();
    div[7:0] = 8'd2;
    en = 4'b0001;
    h = half_period(2);
    for (int p = 0; p < 10; p++)
      for (int k = 0; k < 2 * int'(h); k++) cyc("div2_wave", 4'(k < int'(h)), 4'b0001);

    // ratio change mid-high: old halves finish, new ratio from next rising boundary
    do_reset();
    en = 4'b0001;
    cyc("div0_hi", 4'b0001, 4'b0001);
    cyc("div0_lo", 4'b0000, 4'b0001);
    cyc("div0_hi2", 4'b0001, 4'b0001);
    div[7:0] = 8'd3;
    cyc("div0_old_lo", 4'b0000, 4'b0001);
    h = half_period(3);
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 2 * int'(h); k++) cyc("div3_wave", 4'(k < int'(h)), 4'b0001);

    // EN dropped one cycle into the high half, INV flipped while running
    do_reset();
    inv = 4'b0001;
    div[7:0] = 8'd4;
    cyc("stop_inv", 4'b0001, 4'b0000);
    en = 4'b0001;
    cyc("start_inv", 4'b0000, 4'b0001);
    en = 4'b0000;
    inv = 4'b0000;
    h = half_period(4);
    for (int k = 1; k < int'(h); k++) cyc("drop_hi", 4'b0000, 4'b0001);
    for (int k = 0; k < int'(h); k++) cyc("drop_lo", 4'b0001, 4'b0001);
    cyc("drop_stop", 4'b0001, 4'b0000);
    cyc("drop_newinv", 4'b0000, 4'b0000);

    // reset mid-high, then clean restart
    do_reset();
    div[7:0] = 8'd2;
    en = 4'b0001;
    cyc("rst_hi0", 4'b0001, 4'b0001);
    cyc("rst_hi1", 4'b0001, 4'b0001);
    rn = 1'b0;
    cyc("rst_abort", 4'b0000, 4'b0000);
    rn = 1'b1;
    for (int k = 0; k < 12; k++) cyc("rst_restart", 4'((k % 6) < 3), 4'b0001);

`ifdef CLKDIV_SYNC_ALIGN_EN
    do_reset();
    div[7:0] = 8'd1;
    div[15:8] = 8'd3;
    en = 4'b0001;
    tick();
    en = 4'b0011;
    repeat (3) tick();
    sync = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc("sync_align", {2'b00, (k % 8) < 4, (k % 4) < 2}, 4'b0011);
      sync = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
